// File: rtl/result_collector.sv
// Result collector: circular FIFO buffering multiplier products, sequenced per job (collect, drain, flush).
// Optional XOR checksum of accepted words when RESULT_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | no job open, FIFO empty
// COLLECT | job open, accepting products
// DRAIN   | save seen, writes dropped, waiting for FIFO to empty
// FLUSH   | job drained, flushDone asserted for one cycle
module result_collector #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     inValid,
  input  logic [WIDTH-1:0]         inData,
  input  logic                     save,
  input  logic                     outReady,
  output logic                     outValid,
  output logic [WIDTH-1:0]         outData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     flushDone
`ifdef RESULT_CHECKSUM_EN
  ,output logic [WIDTH-1:0]        checksum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  logic             run_q;
  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ok, wr_acc, wr_drop, pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign outValid  = !empty;
  assign outData   = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
  assign flushDone = (state_q == S_FLUSH);

  // run_q holds everything in reset for one edge after rstN rises
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  always_comb begin
    wr_ok      = (state_q == S_IDLE) || (state_q == S_COLLECT);
    wr_acc     = run_q && inValid && !full && wr_ok;
    wr_drop    = run_q && inValid && !wr_acc;
    pop        = run_q && outValid && outReady;
    count_d    = count_q + CW'(wr_acc) - CW'(pop);
    state_d    = state_q;
    overflow_d = overflow_q | wr_drop;
    case (state_q)
      S_IDLE: begin
        if (wr_acc)              state_d = S_COLLECT;
        else if (save && empty)  state_d = S_FLUSH;
      end
      S_COLLECT: if (save) state_d = S_DRAIN;
      // no writes in DRAIN, so count_d == 0 means the last word leaves on this edge
      S_DRAIN:   if (count_d == '0) state_d = S_FLUSH;
      S_FLUSH: begin
        state_d    = S_IDLE;
        overflow_d = 1'b0;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (run_q) begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= inData;
  end

`ifdef RESULT_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      checksum_q <= '0;
    end else if (run_q) begin
      if (state_q == S_FLUSH) checksum_q <= '0;
      else if (wr_acc)        checksum_q <= checksum_q ^ inData;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: queue-based job model compared every cycle, plus directed literal checks.
module tb_result_collector;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             inValid = 1'b0;
  logic [WIDTH-1:0] inData = '0;
  logic             save = 1'b0;
  logic             outReady = 1'b0;
  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic [3:0]       count;
  logic             full, empty, overflow, flushDone;
`ifdef RESULT_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inData(inData), .save(save),
    .outReady(outReady), .outValid(outValid), .outData(outData), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .flushDone(flushDone)
`ifdef RESULT_CHECKSUM_EN
    ,.checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // job model: the FIFO is a queue, the job phase follows the written rules
  typedef enum int {P_IDLE, P_COLLECT, P_DRAIN, P_FLUSH} phase_t;
  logic [WIDTH-1:0] mq[$];
  phase_t           ph, nph;
  bit               m_run, m_ovf, was_full, was_empty, do_pop, do_wr, dropped;
  logic [WIDTH-1:0] m_csum;

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mq.delete();
      ph = P_IDLE; m_run = 1'b0; m_ovf = 1'b0; m_csum = '0;
    end else begin
      if (m_run) begin
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        do_pop    = !was_empty && outReady;
        do_wr     = inValid && !was_full && (ph == P_IDLE || ph == P_COLLECT);
        dropped   = inValid && !do_wr;
        if (do_pop) void'(mq.pop_front());
        if (do_wr)  mq.push_back(inData);
        nph = ph;
        case (ph)
          P_IDLE:    if (do_wr) nph = P_COLLECT; else if (save && was_empty) nph = P_FLUSH;
          P_COLLECT: if (save) nph = P_DRAIN;
          P_DRAIN:   if (mq.size() == 0) nph = P_FLUSH;
          P_FLUSH:   nph = P_IDLE;
          default:   nph = P_IDLE;
        endcase
        if (ph == P_FLUSH)  m_ovf = 1'b0;
        else if (dropped)   m_ovf = 1'b1;
        if (ph == P_FLUSH)  m_csum = '0;
        else if (do_wr)     m_csum = m_csum ^ inData;
        ph = nph;
      end
      m_run = 1'b1;
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_outValid", outValid, mq.size() != 0);
      chk("m_outData", outData, (mq.size() != 0) ? mq[0] : '0);
      chk("m_count", count, mq.size());
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_empty", empty, mq.size() == 0);
      chk("m_overflow", overflow, m_ovf);
      chk("m_flushDone", flushDone, ph == P_FLUSH);
`ifdef RESULT_CHECKSUM_EN
      chk("m_checksum", checksum, m_csum);
`endif
    end
  end

  logic [WIDTH-1:0] popped[$];
  bit rec_en = 1'b0;
  always @(negedge clk) begin
    if (rec_en && outValid && outReady) popped.push_back(outData);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [WIDTH-1:0] d);
    inValid = 1'b1; inData = d;
    cyc();
    inValid = 1'b0;
  endtask

  task automatic wait_flush(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc();
      if (flushDone) seen = 1'b1;
    end
    chk(nm, seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(); cyc();
    cmp_en = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_outValid", outValid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_flushDone", flushDone, 0);
    chk("rst_outData", outData, 0);

    // first edge after release must be ignored
    rstN = 1'b1; inValid = 1'b1; inData = 32'h55;
    cyc();
    inValid = 1'b0;
    chk("sync_count", count, 0);
    chk("sync_overflow", overflow, 0);
    cyc();

    // basic flow
    write(32'h11); write(32'h22); write(32'h33);
    chk("basic_count", count, 3);
    chk("basic_head", outData, 32'h11);
    outReady = 1'b1;
    chk("basic_pop0", outData, 32'h11); cyc();
    chk("basic_pop1", outData, 32'h22); cyc();
    chk("basic_pop2", outData, 32'h33); cyc();
    chk("basic_empty", empty, 1);
    outReady = 1'b0;
    save = 1'b1; cyc(); save = 1'b0;
    wait_flush("basic_flush");
    cyc();

    // overflow
    for (int i = 1; i <= 8; i++) write(32'h100 + i);
    chk("ovf_full", full, 1);
    chk("ovf_count8", count, 8);
    chk("ovf_pre", overflow, 0);
    write(32'h109);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_head", outData, 32'h101);
    outReady = 1'b1; save = 1'b1; cyc(); save = 1'b0;
    wait_flush("ovf_flush");
    chk("ovf_in_flush", overflow, 1);
    cyc();
    chk("ovf_cleared", overflow, 0);
    outReady = 1'b0;

    // wrap-around with simultaneous write and pop
    outReady = 1'b1; rec_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      inValid = 1'b1; inData = 32'h200 + i;
      cyc();
      chk("wrap_count_le1", count <= 1, 1);
    end
    inValid = 1'b0;
    cyc();
    rec_en = 1'b0;
    chk("wrap_npop", popped.size(), 20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      chk("wrap_order", popped[i], 32'h200 + i);
    outReady = 1'b0;
    save = 1'b1; cyc(); save = 1'b0;
    wait_flush("wrap_flush");
    cyc();

    // drain with a late write
    write(32'hA1); write(32'hA2);
    save = 1'b1; cyc(); save = 1'b0;
    write(32'hBAD);
    chk("drain_ovf", overflow, 1);
    chk("drain_count", count, 2);
    outReady = 1'b1;
    cyc();
    chk("drain_fd_early", flushDone, 0);
    chk("drain_second", outData, 32'hA2);
    cyc();
    chk("drain_fd", flushDone, 1);
    chk("drain_fd_count", count, 0);
    outReady = 1'b0;
    cyc();
    chk("drain_fd_off", flushDone, 0);
    chk("drain_idle_ovf", overflow, 0);

    // save in IDLE with nothing queued
    save = 1'b1; cyc(); save = 1'b0;
    chk("idle_save_fd", flushDone, 1);
    cyc();
    chk("idle_save_fd_off", flushDone, 0);

    // reset in the middle of DRAIN
    for (int i = 0; i < 4; i++) write(32'h300 + i);
    save = 1'b1; cyc(); save = 1'b0;
    chk("mid_count_pre", count, 4);
    rstN = 1'b0;
    #1;
    chk("mid_empty", empty, 1);
    chk("mid_count", count, 0);
    chk("mid_outValid", outValid, 0);
    chk("mid_fd", flushDone, 0);
    cyc(); cyc();
    chk("mid_fd_hold", flushDone, 0);
    rstN = 1'b1;
    cyc(); cyc();
    chk("mid_after_fd", flushDone, 0);

`ifdef RESULT_CHECKSUM_EN
    write(32'hF0F0_0000); write(32'h0F0F_00FF);
    chk("csum_value", checksum, 32'hFFFF_00FF);
    outReady = 1'b1; save = 1'b1; cyc(); save = 1'b0;
    wait_flush("csum_flush");
    chk("csum_hold", checksum, 32'hFFFF_00FF);
    cyc();
    chk("csum_clear", checksum, 0);
    outReady = 1'b0;
`endif

    cyc();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
